i2c_scl_gen: RTL and testbench



---
 rtl/i2c_scl_gen.sv | 191 +++++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
// SCL generator for the I2C master. Paces the SDA sequencer via the phase
// counter `contador`: one SCL period is 2*HALF counter steps, each step being
// PRESCALE clk cycles. The high phase is contador 0..HALF-1 and the low phase
// is HALF..2*HALF-1. Slave clock stretching freezes the prescaler while the
// master has released SCL but the line still reads low.
//
// Ports:
//   clk       in     master clock
//   reset     in     synchronous active-low reset
//   start     in     transfer request, level-sampled in IDLE only
//   stop_cond in     stop request from the SDA sequencer
//   scl_m     inout  open-drain SCL (drives 0 or releases to z)
//   contador  out    phase counter 0..2*HALF-1
//   step      out    one-clk pulse on the cycle contador changes
//   busy      out    high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module i2c_scl_gen #(
   parameter int unsigned PRESCALE = 25,
   parameter int unsigned HALF     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop_cond,
   inout  wire        scl_m,
   output logic [4:0] contador,
   output logic       step,
   output logic       busy
);

   localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
   localparam logic [4:0] HALF_C  = 5'(HALF);
   localparam logic [4:0] HALF_M1 = 5'(HALF - 1);
   localparam logic [4:0] LAST_C  = 5'(2 * HALF - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t     state_r;
   logic [4:0] contador_r;
   logic [7:0] prescaler_r;
   logic       step_r;
   logic       busy_r;
   logic       scl_drive_r;
   logic       scl_s_r;
   logic       stop_pend_r;

   logic       wrap_s;
   logic       freeze_s;
   logic       tick_s;

   // Open-drain output: only ever pull low, otherwise let the pull-up win.
   assign scl_m    = scl_drive_r ? 1'bz : 1'b0;
   assign contador = contador_r;
   assign step     = step_r;
   assign busy     = busy_r;

   // Step qualification: the prescaler is at its last count and no slave is
   // stretching a high phase that we have released.
   always_comb begin
      wrap_s = (prescaler_r == PRE_MAX);
      if (((state_r == ST_START) || (state_r == ST_RUN)) &&
          (contador_r < HALF_C) && !scl_s_r) begin
         freeze_s = 1'b1;
      end else begin
         freeze_s = 1'b0;
      end
      tick_s = wrap_s & ~freeze_s;
   end

   // Main FSM: state, phase counter, prescaler, SCL drive and status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         contador_r  <= 5'd0;
         prescaler_r <= 8'd0;
         step_r      <= 1'b0;
         busy_r      <= 1'b0;
         scl_drive_r <= 1'b1;
         scl_s_r     <= 1'b1;
         stop_pend_r <= 1'b0;
      end else begin
         // A floating (z) line reads as released.
         scl_s_r <= (scl_m === 1'b0) ? 1'b0 : 1'b1;
         step_r  <= 1'b0;

         // The prescaler parks on its last count during a stretch, so the
         // step fires on the first cycle the line is seen high again.
         if (state_r == ST_IDLE) begin
            prescaler_r <= 8'd0;
         end else if (wrap_s && !tick_s) begin
            prescaler_r <= PRE_MAX;
         end else if (wrap_s) begin
            prescaler_r <= 8'd0;
         end else begin
            prescaler_r <= prescaler_r + 8'd1;
         end

         case (state_r)
            ST_IDLE: begin
               contador_r  <= 5'd0;
               scl_drive_r <= 1'b1;
               stop_pend_r <= 1'b0;
               if (start) begin
                  state_r <= ST_START;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end

            ST_START, ST_RUN: begin
               busy_r <= 1'b1;
               if (stop_cond && (contador_r < HALF_C)) begin
                  // SCL is already high: stop right away, restarting the
                  // bus-free count from a clean step boundary.
                  state_r     <= ST_STOP;
                  contador_r  <= 5'd0;
                  prescaler_r <= 8'd0;
                  scl_drive_r <= 1'b1;
                  stop_pend_r <= 1'b0;
                  step_r      <= (contador_r != 5'd0);
               end else begin
                  // Low phase: remember the request until the period ends.
                  if (stop_cond) begin
                     stop_pend_r <= 1'b1;
                  end
                  if (tick_s) begin
                     step_r <= 1'b1;
                     if (contador_r == LAST_C) begin
                        contador_r  <= 5'd0;
                        scl_drive_r <= 1'b1;
                        if (stop_pend_r || stop_cond) begin
                           state_r     <= ST_STOP;
                           stop_pend_r <= 1'b0;
                        end else begin
                           state_r <= ST_RUN;
                        end
                     end else if ((contador_r + 5'd1) >= HALF_C) begin
                        contador_r  <= contador_r + 5'd1;
                        scl_drive_r <= 1'b0;
                        state_r     <= ST_RUN;
                     end else begin
                        contador_r  <= contador_r + 5'd1;
                        scl_drive_r <= 1'b1;
                     end
                  end
               end
            end

            ST_STOP: begin
               busy_r      <= 1'b1;
               scl_drive_r <= 1'b1;
               stop_pend_r <= 1'b0;
               // Leave only on a step boundary so the bus-free time spans
               // HALF complete steps.
               if (wrap_s) begin
                  if (contador_r != HALF_M1) begin
                     contador_r <= contador_r + 5'd1;
                     step_r     <= 1'b1;
                  end else if (!stop_cond) begin
                     state_r    <= ST_IDLE;
                     busy_r     <= 1'b0;
                     contador_r <= 5'd0;
                     step_r     <= 1'b1;
                  end else begin
                     contador_r <= HALF_M1;
                  end
               end
            end

            default: begin
               state_r     <= ST_IDLE;
               contador_r  <= 5'd0;
               prescaler_r <= 8'd0;
               busy_r      <= 1'b0;
               scl_drive_r <= 1'b1;
               stop_pend_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// tb_i2c_scl_gen
// Self-checking bench for i2c_scl_gen with PRESCALE=4, HALF=5 and a pulled-up
// SCL line that the bench can hold low to emulate a stretching slave.
// Expected records are queued when stimulus is applied and popped/compared
// once the programmed number of clock edges has elapsed.
// -----------------------------------------------------------------------------
module tb_i2c_scl_gen;

   localparam int PRESCALE = 4;
   localparam int HALF     = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop_cond;
   logic       hold;
   wire        scl_line;
   logic [4:0] contador;
   logic       step;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         id;
      int         n;
      logic       st;
      logic       sp;
      logic       hold;
      logic [4:0] cnt;
      logic       chk_step;
      logic       stp;
      logic       bsy;
      logic       scl;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[12];

   pullup (scl_line);
   assign scl_line = hold ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_scl_gen #(.PRESCALE(PRESCALE), .HALF(HALF)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop_cond(stop_cond),
      .scl_m    (scl_line),
      .contador (contador),
      .step     (step),
      .busy     (busy)
   );

   function automatic vec_t mk(input int id, input int n, input logic st,
                               input logic sp, input logic hd,
                               input logic [4:0] cnt, input logic cs,
                               input logic stp, input logic bsy,
                               input logic scl);
      vec_t v;
      v.id = id; v.n = n; v.st = st; v.sp = sp; v.hold = hd;
      v.cnt = cnt; v.chk_step = cs; v.stp = stp; v.bsy = bsy; v.scl = scl;
      return v;
   endfunction

   // Advance n clock edges, ending 1 time unit after the last edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_pop();
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if ((contador !== e.cnt) || (busy !== e.bsy) || (scl_line !== e.scl) ||
          (e.chk_step && (step !== e.stp))) begin
         failures++;
         $display("FAIL vec%0d: got cnt=%0d step=%0b busy=%0b scl=%0b, want cnt=%0d step=%0b(chk=%0b) busy=%0b scl=%0b",
                  e.id, contador, step, busy, scl_line, e.cnt, e.stp, e.chk_step, e.bsy, e.scl);
      end
   endtask

   task automatic apply(input vec_t v);
      start     = v.st;
      stop_cond = v.sp;
      hold      = v.hold;
      exp_q.push_back(v);
      cyc(v.n);
      check_pop();
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Wait (bounded) for busy to drop; then IDLE must show contador=0, SCL high.
   task automatic wait_idle(input string name, input int budget);
      int found;
      found = 0;
      for (int i = 0; i < budget; i++) begin
         cyc(1);
         if (busy == 1'b0) begin
            found = 1;
            break;
         end
      end
      chk({name, "_idle"}, found, 1);
      chk({name, "_cnt"}, int'(contador), 0);
      chk({name, "_scl"}, int'(scl_line), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int found;
      int k;
      logic [4:0] ecnt;

      reset = 1'b0; start = 1'b0; stop_cond = 1'b0; hold = 1'b0;

      // Nominal transfer: START 0..4 over 20 clks, then 40-clk SCL periods.
      tbl[0]  = mk(10,  1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[1]  = mk(11,  3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[2]  = mk(12,  1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[3]  = mk(13,  2, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[4]  = mk(14,  2, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[5]  = mk(15,  8, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[6]  = mk(16,  3, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[7]  = mk(17,  1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      tbl[8]  = mk(18, 19, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      tbl[9]  = mk(19,  1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[10] = mk(20, 19, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[11] = mk(21,  1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset state, then idle with start low.
      apply(mk(1, 3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      reset = 1'b1;
      apply(mk(2, 2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1));

      for (int i = 0; i < 12; i++) begin
         apply(tbl[i]);
      end

      // Clock stretching: slave holds SCL low across the release at contador=0.
      apply(mk(30, 19, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0));
      apply(mk(31,  1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 30; i++) begin
         apply(mk(100 + i, 1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      end
      hold  = 1'b0;
      found = 0;
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         if (step == 1'b1) begin
            found = 1;
            break;
         end
      end
      chk("stretch_resume", found, 1);
      chk("stretch_resume_cnt", int'(contador), 1);
      apply(mk(40,  4, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1));
      apply(mk(41, 12, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));

      // Stop requested at contador=7: finish the period, then STOP holds at 4.
      apply(mk(42,  8, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0));
      apply(mk(43, 12, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1));
      apply(mk(44, 24, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1));
      stop_cond = 1'b0;
      wait_idle("stop_run", 8);

      // start held high, stop during START at contador=2: SCL never goes low.
      apply(mk(50, 1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
      apply(mk(51, 8, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1));
      apply(mk(52, 1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 1; i <= 20; i++) begin
         k    = i / 4;
         ecnt = (k > 4) ? 5'd4 : 5'(k);
         apply(mk(60 + i, 1, 1'b1, 1'b1, 1'b0, ecnt, 1'b1,
                  ((i % 4) == 0) && (i <= 16), 1'b1, 1'b1));
      end
      stop_cond = 1'b0;
      wait_idle("stop_start", 8);
      apply(mk(53, 1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));

      // Reset in RUN at contador=8 releases the line on the next edge.
      apply(mk(54, 32, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
      reset = 1'b0;
      apply(mk(55, 1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1));
      reset = 1'b1;
      apply(mk(56, 4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
